// File: rtl/spi_master_mc.sv
// Multi-slave SPI master: per-frame mode, divider, length and slave select,
// with chip select optionally held across frames to form bursts.
module spi_master_mc #(
    parameter int DATA_W = 64,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8,
    localparam int LEN_W = $clog2(DATA_W + 1),
    localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [LEN_W-1:0]  tx_len,
    input  logic [CS_W-1:0]   tx_cs_sel,
    input  logic              tx_last,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);

    // state      | meaning
    // IDLE       | waiting for a command, CS released
    // SETUP      | CS asserted, first bit settling before the leading edge
    // XFER       | 2N SCK edges, shifting out and sampling in
    // HOLD       | SCK back at CPOL, CS still asserted
    // BURST_WAIT | CS held low, waiting for the next burst frame
    // GAP        | CS released, minimum deselect time before IDLE
    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, BURST_WAIT, GAP} state_t;

    state_t            state, state_nx;
    logic [DIV_W-1:0]  tmr, div_r, div_eff;
    logic [LEN_W:0]    edges_left;
    logic [DATA_W-1:0] tx_sh, rx_sh, aligned;
    logic [CS_W-1:0]   sel_r, sel_eff;
    logic [LEN_W-1:0]  len_eff, sh_amt;
    logic [NUM_CS-1:0] cs_onehot;
    logic              last_r, cpol_r, cpha_r, cpha_eff;
    logic              tc, accept, edge_evt, lead, final_edge, drive, sample;
    logic              from_idle, cs_act_nx;

    assign tc         = (tmr == '0);
    assign from_idle  = (state == IDLE);
    assign lead       = ~edges_left[0];
    assign final_edge = (edges_left == (LEN_W+1)'(1));
    assign busy       = (state != IDLE) || (cs_n != '1);

    // Command fields: burst frames keep the select/mode/divider of the first frame.
    always_comb begin
        len_eff = tx_len;
        if (tx_len == '0 || tx_len > LEN_W'(DATA_W))
            len_eff = LEN_W'(DATA_W);
        sh_amt    = LEN_W'(DATA_W) - len_eff;
        aligned   = tx_data << sh_amt;
        cpha_eff  = from_idle ? cfg_cpha  : cpha_r;
        div_eff   = from_idle ? cfg_div   : div_r;
        sel_eff   = from_idle ? tx_cs_sel : sel_r;
        cs_onehot = NUM_CS'(1) << sel_eff;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        edge_evt = 1'b0;
        tx_ready = ~rst & ((state == IDLE) || (state == BURST_WAIT));
        case (state)
            IDLE, BURST_WAIT: begin
                if (tx_valid) begin
                    accept   = 1'b1;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                if (tc) begin
                    edge_evt = 1'b1;
                    state_nx = XFER;
                end
            end
            XFER: begin
                if (tc) begin
                    if (edges_left == '0) state_nx = HOLD;
                    else                  edge_evt = 1'b1;
                end
            end
            HOLD:    if (tc) state_nx = last_r ? GAP : BURST_WAIT;
            GAP:     if (tc) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        cs_act_nx = state_nx inside {SETUP, XFER, HOLD, BURST_WAIT};
        // CPHA=0 presents the first bit at accept and shifts on trailing edges
        // (never after the last one); CPHA=1 shifts on leading edges.
        if (accept) drive = ~cpha_eff;
        else        drive = edge_evt & (cpha_r ? lead : (~lead & ~final_edge));
        sample = edge_evt & (cpha_r ? ~lead : lead);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr        <= '0;
            edges_left <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            sel_r      <= '0;
            last_r     <= 1'b0;
            cpol_r     <= 1'b0;
            cpha_r     <= 1'b0;
            div_r      <= '0;
            sck        <= 1'b0;
            mosi       <= 1'b0;
            cs_n       <= '1;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
        end else begin
            rx_valid <= 1'b0;
            cs_n     <= cs_act_nx ? ~cs_onehot : '1;
            if (accept) begin
                tmr        <= div_eff;
                edges_left <= {len_eff, 1'b0};
                rx_sh      <= '0;
                last_r     <= tx_last;
                if (from_idle) begin
                    sel_r  <= tx_cs_sel;
                    cpol_r <= cfg_cpol;
                    cpha_r <= cfg_cpha;
                    div_r  <= cfg_div;
                end
            end else if (state != IDLE && state != BURST_WAIT) begin
                tmr <= tc ? div_r : tmr - DIV_W'(1);
            end
            if (state == IDLE)  sck <= cfg_cpol;
            else if (edge_evt)  sck <= ~sck;
            if (edge_evt) edges_left <= edges_left - (LEN_W+1)'(1);
            if (accept) begin
                tx_sh <= drive ? (aligned << 1) : aligned;
                if (drive) mosi <= aligned[DATA_W-1];
            end else if (drive) begin
                mosi  <= tx_sh[DATA_W-1];
                tx_sh <= tx_sh << 1;
            end
            if (sample) rx_sh <= {rx_sh[DATA_W-2:0], miso};
            if (state == HOLD && tc) begin
                rx_valid <= 1'b1;
                rx_data  <= rx_sh;
            end
        end
    end

endmodule
